// File: rtl/cska_alu_controller_if.sv
// Handshake and data bus of the block-serial carry-skip ALU controller.
//   master : drives in_i, cin_i, store_a_i, start_i, mode_i; receives the results
//   slave  : the controller itself
//   in_i       operand bus (A on store_a_i, B on start_i)
//   cin_i      carry in for ADD/ACC/SBC
//   store_a_i  load A from in_i (idle only)
//   start_i    begin an operation (idle only)
//   mode_i     00 ADD, 01 SUB, 10 ACC, 11 SBC
//   busy_o     operation in progress
//   done_o     one-cycle result-valid pulse
//   out_o      result, held between done pulses
//   cout_o     carry out of the MSB
//   ovf_o      signed overflow
//   skip_cnt_o blocks whose carry was skipped in the last operation
interface cska_alu_controller_if #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam int SKW  = $clog2(NBLK + 1);

  logic [WIDTH-1:0] in_i;
  logic             cin_i;
  logic             store_a_i;
  logic             start_i;
  logic [1:0]       mode_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] out_o;
  logic             cout_o;
  logic             ovf_o;
  logic [SKW-1:0]   skip_cnt_o;

  modport master (
    output in_i, cin_i, store_a_i, start_i, mode_i,
    input  busy_o, done_o, out_o, cout_o, ovf_o, skip_cnt_o
  );

  modport slave (
    input  in_i, cin_i, store_a_i, start_i, mode_i,
    output busy_o, done_o, out_o, cout_o, ovf_o, skip_cnt_o
  );
endinterface

// File: rtl/cska_alu_controller.sv
// Block-serial carry-skip add/subtract controller.
// Holds operand A, processes one BLOCK-bit slice per clock and publishes
// out/cout/ovf/skip_cnt together with a one-cycle done pulse.
//   clk   rising-edge clock
//   rst_n synchronous active-low reset
//   bus   cska_alu_controller_if.slave (operands, mode, handshake, results)
//
// state  | meaning
// S_IDLE | waiting for start_i; store_a_i loads A
// S_RUN  | one carry-skip block per cycle, blk_q = block index
module cska_alu_controller #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cska_alu_controller_if.slave   bus
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam int SKW  = $clog2(NBLK + 1);
  localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic             acc_q;
  logic [BW-1:0]    blk_q;
  logic [SKW-1:0]   skip_q;
  logic [WIDTH-1:0] out_q;
  logic             cout_q, ovf_q, done_q;
  logic [SKW-1:0]   skip_cnt_q;

  logic [BLOCK-1:0] a_blk, b_blk, s_blk;
  logic             p_all, c_msb_blk, blk_cout, c_rip, last_blk;
  logic [WIDTH-1:0] sum_d;

  // Current block: ripple sum plus skip-multiplexed carry out.
  always_comb begin
    a_blk     = a_q[blk_q*BLOCK +: BLOCK];
    b_blk     = b_q[blk_q*BLOCK +: BLOCK];
    s_blk     = '0;
    c_msb_blk = 1'b0;
    c_rip     = carry_q;
    for (int k = 0; k < BLOCK; k++) begin
      s_blk[k] = a_blk[k] ^ b_blk[k] ^ c_rip;
      if (k == BLOCK - 1) c_msb_blk = c_rip;
      c_rip = (a_blk[k] & b_blk[k]) | (c_rip & (a_blk[k] ^ b_blk[k]));
    end
    p_all    = &(a_blk ^ b_blk);
    blk_cout = p_all ? carry_q : c_rip;
    sum_d    = sum_q;
    sum_d[blk_q*BLOCK +: BLOCK] = s_blk;
    last_blk = (blk_q == BW'(NBLK - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start_i) state_d = S_RUN;
      S_RUN:  if (last_blk)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o     = (state_q == S_RUN);
    bus.done_o     = done_q;
    bus.out_o      = out_q;
    bus.cout_o     = cout_q;
    bus.ovf_o      = ovf_q;
    bus.skip_cnt_o = skip_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      acc_q      <= 1'b0;
      blk_q      <= '0;
      skip_q     <= '0;
      out_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      skip_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            // mode bit 0 set means subtract-type: use the inverted operand
            b_q     <= bus.mode_i[0] ? ~bus.in_i : bus.in_i;
            carry_q <= (bus.mode_i == 2'b01) ? 1'b1 : bus.cin_i;
            acc_q   <= (bus.mode_i == 2'b10);
            blk_q   <= '0;
            skip_q  <= '0;
            sum_q   <= '0;
          end else if (bus.store_a_i) begin
            a_q <= bus.in_i;
          end
        end
        S_RUN: begin
          sum_q   <= sum_d;
          carry_q <= blk_cout;
          skip_q  <= skip_q + SKW'(p_all);
          blk_q   <= blk_q + BW'(1);
          if (last_blk) begin
            out_q      <= sum_d;
            cout_q     <= blk_cout;
            ovf_q      <= c_msb_blk ^ blk_cout;
            skip_cnt_q <= skip_q + SKW'(p_all);
            done_q     <= 1'b1;
            if (acc_q) a_q <= sum_d;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cska_alu_controller.sv
module tb_cska_alu_controller;
  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
  localparam int NBLK  = 4;
  localparam logic [1:0] M_ADD = 2'b00, M_SUB = 2'b01, M_ACC = 2'b10, M_SBC = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cska_alu_controller_if #(.WIDTH(WIDTH), .BLOCK(BLOCK)) bus();
  cska_alu_controller #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [1:0]  mode;
    logic [15:0] eo;
    logic        ec;
    logic        ev;
    logic [2:0]  es;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic store(input logic [15:0] a);
    bus.store_a_i = 1'b1;
    bus.in_i = a;
    @(posedge clk); #1;
    bus.store_a_i = 1'b0;
  endtask

  task automatic start_op(input logic [15:0] b, input logic c, input logic [1:0] m);
    bus.in_i = b; bus.cin_i = c; bus.mode_i = m; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    // scramble inputs during RUN; they must not matter
    bus.in_i = 16'($urandom); bus.cin_i = ~c; bus.mode_i = ~m;
  endtask

  task automatic wait_done(input bit inject, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (inject && n == 1) begin
        bus.start_i = 1'b1; bus.store_a_i = 1'b1; bus.in_i = 16'hDEAD;
      end else if (inject && n == 2) begin
        bus.start_i = 1'b0; bus.store_a_i = 1'b0;
      end
    end while (!bus.done_o && n < 20);
  endtask

  task automatic check_result(input string nm, input int n, input logic [15:0] eo,
                              input logic ec, input logic ev, input logic [2:0] es);
    chk({nm, ".latency"}, n, NBLK);
    chk({nm, ".done"}, bus.done_o, 1);
    chk({nm, ".busy"}, bus.busy_o, 0);
    chk({nm, ".out"}, bus.out_o, eo);
    chk({nm, ".cout"}, bus.cout_o, ec);
    chk({nm, ".ovf"}, bus.ovf_o, ev);
    chk({nm, ".skip"}, bus.skip_cnt_o, es);
    @(posedge clk); #1;
    chk({nm, ".done_pulse"}, bus.done_o, 0);
    chk({nm, ".out_hold"}, bus.out_o, eo);
  endtask

  task automatic watch_no_done(input string nm);
    int extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done_o) extra++;
    end
    chk(nm, extra, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{"add_basic", 16'h1234, 16'h0FFF, 1'b0, M_ADD, 16'h2233, 1'b0, 1'b0, 3'd0};
    vecs[1] = '{"add_allskip", 16'h5555, 16'hAAAA, 1'b1, M_ADD, 16'h0000, 1'b1, 1'b0, 3'd4};
    vecs[2] = '{"add_ovf", 16'h7FFF, 16'h0001, 1'b0, M_ADD, 16'h8000, 1'b0, 1'b1, 3'd2};
    vecs[3] = '{"sub_borrow", 16'h0005, 16'h0007, 1'b1, M_SUB, 16'hFFFE, 1'b0, 1'b0, 3'd3};
    vecs[4] = '{"sbc_cin0", 16'h0005, 16'h0005, 1'b0, M_SBC, 16'hFFFF, 1'b0, 1'b0, 3'd4};
    vecs[5] = '{"sub_ovf", 16'h8000, 16'h0001, 1'b0, M_SUB, 16'h7FFF, 1'b1, 1'b1, 3'd2};
    vecs[6] = '{"add_max", 16'hFFFF, 16'hFFFF, 1'b1, M_ADD, 16'hFFFF, 1'b1, 1'b0, 3'd0};
    vecs[7] = '{"sub_zero", 16'h0000, 16'h0000, 1'b0, M_SUB, 16'h0000, 1'b1, 1'b0, 3'd4};
    vecs[8] = '{"sbc_cin1", 16'h0003, 16'h0001, 1'b1, M_SBC, 16'h0002, 1'b1, 1'b0, 3'd3};

    // reset with garbage on the inputs
    bus.in_i = 16'($urandom); bus.cin_i = 1'b1; bus.mode_i = 2'($urandom);
    bus.start_i = 1'b1; bus.store_a_i = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", bus.busy_o, 0);
    chk("rst.done", bus.done_o, 0);
    chk("rst.out", bus.out_o, 0);
    chk("rst.cout", bus.cout_o, 0);
    chk("rst.ovf", bus.ovf_o, 0);
    chk("rst.skip", bus.skip_cnt_o, 0);
    bus.start_i = 1'b0; bus.store_a_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    store(16'h4321);
    start_op(16'h0000, 1'b0, M_ADD);
    wait_done(1'b0, n);
    check_result("rst_passthru", n, 16'h4321, 1'b0, 1'b0, 3'd0);

    for (int i = 0; i < 9; i++) begin
      store(vecs[i].a);
      start_op(vecs[i].b, vecs[i].cin, vecs[i].mode);
      wait_done(1'b0, n);
      check_result(vecs[i].name, n, vecs[i].eo, vecs[i].ec, vecs[i].ev, vecs[i].es);
    end

    // accumulate three times, restarting in the done cycle
    store(16'h0000);
    start_op(16'h0003, 1'b0, M_ACC);
    wait_done(1'b0, n);
    chk("acc1.latency", n, NBLK);
    chk("acc1.out", bus.out_o, 16'h0003);
    bus.in_i = 16'h0003; bus.cin_i = 1'b0; bus.mode_i = M_ACC; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    wait_done(1'b1, n);
    chk("acc2.latency", n, NBLK);
    chk("acc2.out", bus.out_o, 16'h0006);
    bus.in_i = 16'h0003; bus.cin_i = 1'b0; bus.mode_i = M_ACC; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    wait_done(1'b0, n);
    chk("acc3.latency", n, NBLK);
    chk("acc3.out", bus.out_o, 16'h0009);
    chk("acc3.cout", bus.cout_o, 0);
    watch_no_done("acc.no_extra_done");
    start_op(16'h0000, 1'b0, M_ADD);
    wait_done(1'b0, n);
    check_result("acc_readback", n, 16'h0009, 1'b0, 1'b0, 3'd0);

    // reset in the second RUN cycle aborts the operation
    store(16'h00FF);
    start_op(16'h0001, 1'b0, M_ADD);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort.busy", bus.busy_o, 0);
    chk("abort.done", bus.done_o, 0);
    chk("abort.out", bus.out_o, 0);
    rst_n = 1'b1;
    watch_no_done("abort.no_done");
    start_op(16'h0000, 1'b0, M_ADD);
    wait_done(1'b0, n);
    check_result("abort_a_cleared", n, 16'h0000, 1'b0, 1'b0, 3'd0);
    store(16'h1111);
    start_op(16'h2222, 1'b0, M_ADD);
    wait_done(1'b0, n);
    check_result("abort_fresh", n, 16'h3333, 1'b0, 1'b0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cska_alu_controller.md
Name: cska_alu_controller

Overview:
- Parametrised successor to the 8-bit carry-skip adder controller.
- Holds operand A in a register and runs a block-serial carry-skip add/subtract on A and the `in` bus, one skip block per clock.
- Reports carry, signed overflow and skip statistics, with a start/busy/done handshake.
- Sits between the datapath input bus and downstream consumers of the ALU result; the ACC mode supports running accumulation.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of BLOCK.
BLOCK, 4, carry-skip block size in bits; NBLK = WIDTH/BLOCK blocks processed, one per cycle.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in  input  WIDTH  operand bus; data for store_A or operand B at start
cin  input  1  carry in for ADD/ACC/SBC; ignored for SUB
store_A  input  1  load A <= in at clock edge (IDLE only)
start  input  1  begin operation (IDLE only)
mode  input  2  00 ADD A+in+cin; 01 SUB A+~in+1; 10 ACC A+in+cin, result written back to A; 11 SBC A+~in+cin
busy  output  1  operation in progress
done  output  1  one-cycle pulse: result valid
out  output  WIDTH  result, held until next done
cout  output  1  carry out of MSB (for SUB/SBC: 1 = no borrow)
ovf  output  1  signed overflow = carry into MSB XOR cout
skip_cnt  output  clog2(NBLK+1)  number of blocks in the last operation whose carry was skipped (all propagate bits = 1)

Behaviour:
- Reset (rst_n low at edge): A=0, out=0, cout=0, ovf=0, skip_cnt=0, busy=0, done=0, FSM=IDLE.
- Reset mid-operation aborts the operation: no done pulse; A cleared even in ACC mode.
- FSM has states IDLE and RUN.
- IDLE, start=1 at edge E0:
  - Latch B_eff = in (ADD/ACC) or ~in (SUB/SBC).
  - Latch carry = cin (ADD/ACC/SBC) or 1 (SUB), and mode.
  - Set blk=0, busy=1; go to RUN.
- IDLE, store_A=1 with start=0: A <= in. store_A and start in the same cycle: start wins and store_A is ignored.
- RUN, edge E(i+1), i = 0..NBLK-1:
  - Process bits [i*BLOCK +: BLOCK] into an internal sum register.
  - Block carry-out = carry-in if all p = A^B_eff bits in the block are 1 (skip; increment internal skip counter), else the ripple carry.
  - Capture carry into the MSB on the last block.
- At edge E_NBLK:
  - out, cout, ovf and skip_cnt update together; done=1 for exactly one cycle; busy=0; FSM returns to IDLE.
  - ACC mode: A <= result at the same edge.
- Latency: done visible NBLK cycles after the start edge. A new start may be sampled in the cycle done is high.
- start and store_A while busy are ignored. Changes on `in`, `mode` or `cin` during RUN have no effect.
- out, cout, ovf and skip_cnt are stable between done pulses; partial sums are never visible on out.
- Arithmetic is modulo 2^WIDTH; the carry out of the MSB appears only on cout.

Test Plan:
- Reset: drive random inputs, hold rst_n=0 for 2 cycles -> all outputs 0, busy=0; store_A then ADD in=0, cin=0 gives out=A.
- WIDTH=16, BLOCK=4: store_A in=0x1234; start ADD in=0x0FFF cin=0 -> done exactly 4 cycles after start; out=0x2233, cout=0, ovf=0, skip_cnt=0.
- A=0x5555; ADD in=0xAAAA cin=1 -> out=0x0000, cout=1, ovf=0, skip_cnt=4. Then A=0x7FFF; ADD in=0x0001 cin=0 -> out=0x8000, ovf=1, cout=0.
- A=0x0005; SUB in=0x0007 -> out=0xFFFE, cout=0, ovf=0. SBC in=0x0005 cin=0 -> out=0xFFFF, cout=0.
- A=0; ACC in=0x0003 three times back-to-back, restarting in the done cycle -> out=0x0009 and A=0x0009. A start pulse and a store_A pulse mid-RUN are ignored, with no extra done.
- Start ADD, pull rst_n low at the 2nd RUN cycle -> no done pulse; busy=0 and A=0 next cycle; a fresh operation afterwards completes correctly.
